// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-and-add multiplier, one multiplier bit per clock.
// Unsigned or two's-complement operation is chosen per transaction by is_signed.
// The magnitudes of the operands are multiplied, and the sign is applied to the final sum.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, is_signed)
//   out_valid / out_ready result handshake (p, 2W bits, held stable while out_valid)
//
// Optional feature: define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero. Without it the latency is always W cycles.
module seq_shift_add_mult #(
  parameter int unsigned W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p
);

  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mag_a_q, mag_a_d;
  logic [W-1:0]    mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*W-1:0]  p_q, p_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [2*W-1:0]  a_ext;
  logic [2*W-1:0]  acc_sum;
  logic [W-1:0]    mag_b_shift;
  logic            last_iter;

  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    count_d     = count_q;
    p_d         = p_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    a_ext       = {{W{1'b0}}, mag_a_q};
    acc_sum     = mag_b_q[0] ? (acc_q + (a_ext << count_q)) : acc_q;
    mag_b_shift = mag_b_q >> 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    last_iter   = (count_q == CW'(W - 1)) || (mag_b_shift == '0);
`else
    last_iter   = (count_q == CW'(W - 1));
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          // |-(2^(W-1))| wraps to 2^(W-1), which is still correct as an unsigned W-bit value.
          mag_a_d    = (is_signed && a[W-1]) ? -a : a;
          mag_b_d    = (is_signed && b[W-1]) ? -b : b;
          neg_d      = is_signed && (a[W-1] ^ b[W-1]);
          acc_d      = '0;
          count_d    = '0;
          in_ready_d = 1'b0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        acc_d   = acc_sum;
        mag_b_d = mag_b_shift;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          // Negating a zero sum yields zero, so a zero product never comes out negative.
          p_d         = neg_q ? -acc_sum : acc_sum;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule
